// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code receive blocks.
// Used by johnson_decode and johnson_seq_checker (optional JOHNSON_HOLD_ALLOW_EN lives in the top).
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic int idx_w(input int width);
    return $clog2(2 * width);
  endfunction

  // Index that should follow idx in a sequence of length len.
  function automatic int unsigned succ_idx(input int unsigned idx, input int unsigned len);
    return (idx + 1 == len) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson codeword decoder: legality check and state index.
// Index is forced to 0 for illegal words.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [IDX_W-1:0] SEQ_LEN = IDX_W'(2 * WIDTH);

  logic [WIDTH-1:0] inv;
  logic [IDX_W-1:0] pop;
  logic [IDX_W-1:0] idx_raw;

  always_comb begin
    inv = ~code;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + IDX_W'(code[i]);
    // Upper half of the sequence drains ones from the LSB end.
    if (!code[WIDTH-1]) begin
      legal   = ((code & (code + ONE)) == '0);
      idx_raw = pop;
    end else begin
      legal   = ((inv & (inv + ONE)) == '0);
      idx_raw = SEQ_LEN - pop;
    end
    index = legal ? idx_raw : '0;
  end

endmodule

// File: rtl/johnson_seq_checker.sv
// Johnson sequence checker: decode, successor check, lock FSM, saturating error count.
// Define JOHNSON_HOLD_ALLOW_EN to treat a repeated legal word as neutral.
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int LOCK_CNT = 2,
  parameter  int ERR_W    = 8,
  localparam int IDX_W    = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             out_legal,
  output logic             lock,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int             RUN_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state, state_nx;
  logic [IDX_W-1:0] prev_idx, prev_nx;
  logic [RUN_W-1:0] run, run_nx, run_inc;
  logic [ERR_W-1:0] err_base, err_nx;
  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] succ;
  logic             is_succ, is_hold, err_ev;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (in_code),
    .legal (dec_legal),
    .index (dec_idx)
  );

  assign succ    = IDX_W'(succ_idx(32'(prev_idx), 2 * WIDTH));
  assign is_succ = dec_legal && (dec_idx == succ);
  assign run_inc = run + RUN_W'(1);

`ifdef JOHNSON_HOLD_ALLOW_EN
  assign is_hold = dec_legal && (dec_idx == prev_idx);
`else
  assign is_hold = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    prev_nx  = prev_idx;
    run_nx   = run;
    err_ev   = 1'b0;
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (dec_legal) begin
            state_nx = HUNT;
            prev_nx  = dec_idx;
            run_nx   = '0;
          end
        end
        HUNT: begin
          if (!dec_legal) begin
            state_nx = IDLE;
            run_nx   = '0;
          end else if (is_hold) begin
            state_nx = HUNT;
          end else if (is_succ) begin
            prev_nx = dec_idx;
            if (run_inc == RUN_TGT) begin
              state_nx = LOCKED;
              run_nx   = '0;
            end else begin
              run_nx = run_inc;
            end
          end else begin
            prev_nx = dec_idx;
            run_nx  = '0;
          end
        end
        LOCKED: begin
          if (is_succ) begin
            prev_nx = dec_idx;
          end else if (!is_hold) begin
            err_ev = 1'b1;
            run_nx = '0;
            if (!dec_legal) begin
              state_nx = IDLE;
            end else begin
              state_nx = HUNT;
              prev_nx  = dec_idx;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Clear takes effect before the increment of the same cycle.
  always_comb begin
    err_base = clr_err ? '0 : err_count;
    err_nx   = (err_ev && (err_base != ERR_MAX)) ? err_base + ERR_W'(1) : err_base;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prev_idx <= '0;
      run      <= '0;
    end else begin
      state    <= state_nx;
      prev_idx <= prev_nx;
      run      <= run_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_legal <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= in_valid;
      err_count <= err_nx;
      seq_err   <= err_ev;
      if (in_valid) begin
        out_index <= dec_idx;
        out_legal <= dec_legal;
      end
    end
  end

  assign lock = (state == LOCKED);

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Scoreboard bench for johnson_seq_checker (WIDTH=8, LOCK_CNT=2, ERR_W=2).
// Reference model works on a generated codeword table and integer indices.
module tb_johnson_seq_checker;

  localparam int W       = 8;
  localparam int LEN     = 2 * W;
  localparam int LCNT    = 2;
  localparam int EW      = 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_code = '0;
  logic         clr_err = 1'b0;
  logic         out_valid;
  logic [3:0]   out_index;
  logic         out_legal;
  logic         lock;
  logic         seq_err;
  logic [EW-1:0] err_count;

  johnson_seq_checker #(.WIDTH(W), .LOCK_CNT(LCNT), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_err(clr_err),
    .out_valid(out_valid), .out_index(out_index), .out_legal(out_legal),
    .lock(lock), .seq_err(seq_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int legal;
    int lck;
    int serr;
    int ecnt;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_mon;
  logic [W-1:0] tbl[LEN];
  int           n_checks = 0;
  int           n_err = 0;

  bit m_have, m_locked;
  int m_prev, m_run, m_ecnt, m_hidx, m_hlegal;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [W-1:0] c);
    for (int i = 0; i < LEN; i++) if (tbl[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_prev = 0; m_run = 0;
    m_ecnt = 0; m_hidx = 0; m_hlegal = 0;
    exp_q.delete();
  endtask

  task automatic model(input bit v, input logic [W-1:0] code, input bit clr);
    int  idx;
    bit  legal, hold, succ, err;
    exp_t e;
    idx   = lookup(code);
    legal = (idx >= 0);
    err   = 0;
    if (v) begin
      succ = legal && (idx == (m_prev + 1) % LEN);
`ifdef JOHNSON_HOLD_ALLOW_EN
      hold = legal && (idx == m_prev);
`else
      hold = 0;
`endif
      if (!m_have) begin
        if (legal) begin m_have = 1; m_prev = idx; m_run = 0; end
      end else if (hold) begin
      end else if (!m_locked) begin
        if (!legal) begin m_have = 0; m_run = 0; end
        else if (succ) begin
          m_prev = idx;
          m_run++;
          if (m_run == LCNT) begin m_locked = 1; m_run = 0; end
        end else begin m_prev = idx; m_run = 0; end
      end else begin
        if (succ) m_prev = idx;
        else begin
          err = 1; m_locked = 0; m_run = 0;
          if (!legal) m_have = 0;
          else m_prev = idx;
        end
      end
    end
    if (clr) m_ecnt = 0;
    if (err && m_ecnt < ERR_MAX) m_ecnt++;
    if (v) begin
      m_hidx   = legal ? idx : 0;
      m_hlegal = legal;
      e.idx = m_hidx; e.legal = m_hlegal; e.lck = m_locked; e.serr = err; e.ecnt = m_ecnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input logic [W-1:0] code, input bit clr);
    @(negedge clk);
    in_valid = v; in_code = code; clr_err = clr;
    model(v, code, clr);
  endtask

  task automatic feed_idx(input int i);
    step(1, tbl[i % LEN], 0);
  endtask

  task automatic lock_at(input int start);
    for (int k = 0; k < 3; k++) feed_idx(start + k);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("out_index", int'(out_index), e_mon.idx);
          chk("out_legal", int'(out_legal), e_mon.legal);
          chk("lock", int'(lock), e_mon.lck);
          chk("seq_err", int'(seq_err), e_mon.serr);
          chk("err_count", int'(err_count), e_mon.ecnt);
        end
      end else begin
        chk("hold_index", int'(out_index), m_hidx);
        chk("hold_legal", int'(out_legal), m_hlegal);
        chk("hold_lock", int'(lock), int'(m_locked));
        chk("hold_err_count", int'(err_count), m_ecnt);
      end
    end
  end

  initial begin
    logic [W-1:0] c;
    logic [W-1:0] rst_codes[3];
    int cur, r;
    c = '0;
    for (int i = 0; i < LEN; i++) begin
      tbl[i] = c;
      c = {c[W-2:0], ~c[W-1]};
    end
    model_reset();

    // Words offered while reset is held must leave every output at 0.
    rst_codes[0] = 8'b0000_0000; rst_codes[1] = 8'b0000_0001; rst_codes[2] = 8'b0000_0011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1; in_code = rst_codes[k];
      @(posedge clk); #1;
      chk("reset_outputs", int'({out_valid, out_index, out_legal, lock, seq_err, err_count}), 0);
    end
    @(negedge clk);
    in_valid = 0;
    rst = 1;

    // Lock, then run through the wrap 15 -> 0.
    lock_at(0);
    for (int i = 3; i < LEN + 3; i++) feed_idx(i);

    // Illegal word while locked, then relock.
    step(1, 8'b0000_0101, 0);
    lock_at(4);

    // Skip 3 -> 5 while locked, relock, then a repeated word.
    lock_at(1);
    feed_idx(5);
    lock_at(6);
    feed_idx(8);

    // Saturation: five errors, then clear coinciding with an error.
    for (int k = 0; k < 5; k++) begin
      lock_at(k);
      step(1, 8'b0101_0101, 0);
    end
    lock_at(2);
    step(1, 8'b0000_0101, 1);

    // Valid gaps mid-lock.
    lock_at(10);
    for (int k = 0; k < 3; k++) step(0, 8'hA5, 0);
    feed_idx(13);

    // Asynchronous reset mid-lock.
    lock_at(0);
    step(0, 8'h00, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("async_reset_outputs", int'({out_valid, out_index, out_legal, lock, seq_err, err_count}), 0);
    @(negedge clk);
    rst = 1;
    lock_at(7);

    // Randomized traffic.
    cur = 9;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if ($urandom_range(0, 9) == 0) begin
        step(0, W'($urandom), $urandom_range(0, 30) == 0);
      end else if (r < 15) begin
        cur = (cur + 1) % LEN;
        step(1, tbl[cur], $urandom_range(0, 30) == 0);
      end else if (r < 17) begin
        step(1, tbl[cur], 0);
      end else if (r < 18) begin
        cur = $urandom_range(0, LEN - 1);
        step(1, tbl[cur], 0);
      end else begin
        c = W'($urandom);
        if (lookup(c) >= 0) cur = lookup(c);
        step(1, c, $urandom_range(0, 30) == 0);
      end
    end
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
